seg7_scroll: RTL and testbench

Bus-slave nibble buffer that drives the 7-segment display. It scrolls a queue of hex digits across the display window. Software pushes nibbles through bus writes, and the block shifts them one at a time into an NDIGITS-wide window at a programmable rate. After each shift it issues a single-cycle master write carrying the window to the 7-segment driver's digit register. It sits directly upstream of the seg7 driver, between the CPU data bus and the display.

---
 rtl/seg7_scroll.sv | 160 ++++++++++++++++
 tb/tb_seg7_scroll.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll.sv
// Nibble FIFO behind a two-register bus slave; scrolls queued hex digits into a
// display window and pushes each new window to the seg7 digit register.
module seg7_scroll #(
  parameter logic [31:0] BASE     = 32'h20,
  parameter logic [31:0] SEG_BASE = 32'h10,
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        out_enable,
  output logic        out_rw,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [7:0]  status
);

  localparam int WW = 4 * NDIGITS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            run_q, run_d;
  logic [23:0]     period_q, period_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [WW-1:0]   window_q, window_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];

  logic push_wr, ctrl_wr, clear;
  logic empty, full, pop, push_ok, push_drop;
  logic [3:0] count_sat;
  logic unused_data_bits;

  assign unused_data_bits = ^data[7:4];

  // Bus decode and FIFO admission. A push into a full FIFO is only accepted
  // when the scroller pops on the same edge.
  always_comb begin
    push_wr   = enable && rw && (addr == BASE);
    ctrl_wr   = enable && rw && (addr == BASE + 32'd1);
    clear     = ctrl_wr && data[1];
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pop       = (state_q == S_COUNT) && run_q && (cnt_q == period_q) && !empty && !clear;
    push_ok   = push_wr && !clear && (!full || pop);
    push_drop = push_wr && !clear && !push_ok;
  end

  always_comb begin
    run_d      = ctrl_wr ? data[0] : run_q;
    period_d   = ctrl_wr ? data[31:8] : period_q;
    overflow_d = clear ? 1'b0 : (overflow_q || push_drop);
  end

  // Scroll FSM; the counter is frozen in EMIT, so a step takes period+2 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run_q) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!run_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_q) begin
          cnt_d = '0;
          if (!empty) state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_EMIT:  state_d = run_d ? S_COUNT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_EMIT;
      cnt_d   = '0;
    end
  end

  always_comb begin
    window_d = window_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      window_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data[3:0];
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        window_d = {window_q[WW-5:0], mem_q[rd_ptr_q]};
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      period_q   <= '0;
      cnt_q      <= '0;
      window_q   <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      window_q   <= window_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs decode straight from state so reset drops the strobe asynchronously.
  always_comb begin
    if (32'(count_q) >= 32'd15) count_sat = 4'hF;
    else                        count_sat = 4'(count_q);
    out_enable = (state_q == S_EMIT);
    out_rw     = out_enable;
    out_addr   = SEG_BASE;
    out_data   = {{(32 - WW){1'b0}}, window_q};
    status     = {overflow_q, full, empty, run_q, count_sat};
  end

endmodule

// File: tb/tb_seg7_scroll.sv
// Bench for seg7_scroll: randomized pushes and periods checked against a queue
// model of the scrolled window and the period+2 step cadence.
module tb_seg7_scroll;

  localparam logic [31:0] BASE     = 32'h20;
  localparam logic [31:0] SEG_BASE = 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic        out_enable, out_rw;
  logic [31:0] out_addr, out_data;
  logic [7:0]  status;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_wr_cyc;

  int          pulse_cyc_q[$];
  logic [15:0] pulse_dat_q[$];
  logic [15:0] exp_q[$];

  seg7_scroll dut (
    .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr), .data(data),
    .out_enable(out_enable), .out_rw(out_rw), .out_addr(out_addr),
    .out_data(out_data), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_enable === 1'b1) begin
      pulse_cyc_q.push_back(cyc);
      pulse_dat_q.push_back(out_data[15:0]);
    end
  end

  // Called at a negedge; the write is sampled at the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic w);
    enable = 1'b1; rw = w; addr = a; data = d;
    @(negedge clk);
    enable = 1'b0; rw = 1'b0; addr = '0; data = '0;
    last_wr_cyc = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0; rw = 1'b0; addr = '0; data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_cyc_q.delete();
    pulse_dat_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [15:0] shift_in(input logic [15:0] w, input logic [3:0] nib);
    return {w[11:0], nib};
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_enable !== 1'b0) $display("FAIL reset_out_enable: got %b expected 0", out_enable); else n_pass++;
    n_checks++; if (out_rw !== 1'b0) $display("FAIL reset_out_rw: got %b expected 0", out_rw); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 0", out_data); else n_pass++;
    n_checks++; if (out_addr !== SEG_BASE) $display("FAIL reset_out_addr: got %h expected %h", out_addr, SEG_BASE); else n_pass++;
    n_checks++; if (status !== 8'h20) $display("FAIL reset_status: got %h expected 20", status); else n_pass++;
  endtask

  task automatic test_ignored();
    do_reset();
    bus_write(BASE, 32'h5, 1'b0);
    bus_write(BASE + 32'd2, 32'h5, 1'b1);
    bus_write(32'h0, 32'h5, 1'b1);
    bus_write(BASE + 32'd1, 32'h0000_0301, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++; if (status !== 8'h20) $display("FAIL ignored_status: got %h expected 20", status); else n_pass++;
    n_checks++; if (pulse_cyc_q.size() != 0) $display("FAIL ignored_pulses: got %0d expected 0", pulse_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_no_push();
    do_reset();
    bus_write(BASE + 32'd1, {24'd3, 8'h01}, 1'b1);
    repeat (50) @(negedge clk);
    n_checks++; if (pulse_cyc_q.size() != 0) $display("FAIL no_push_pulses: got %0d expected 0", pulse_cyc_q.size()); else n_pass++;
    n_checks++; if (status !== 8'h30) $display("FAIL no_push_status: got %h expected 30", status); else n_pass++;
  endtask

  task automatic test_scroll(input bit fixed);
    int n, per, e;
    logic [15:0] w;
    logic [3:0] nib;
    do_reset();
    n   = fixed ? 5 : $urandom_range(3, 9);
    per = fixed ? 3 : $urandom_range(0, 6);
    w = '0;
    for (int i = 0; i < n; i++) begin
      nib = fixed ? 4'(i + 1) : 4'($urandom_range(0, 15));
      bus_write(BASE, {28'h0, nib}, 1'b1);
      w = shift_in(w, nib);
      exp_q.push_back(w);
    end
    bus_write(BASE + 32'd1, {per[23:0], 8'h01}, 1'b1);
    e = last_wr_cyc;
    repeat ((n + 2) * (per + 2) + 10) @(negedge clk);
    n_checks++;
    if (pulse_cyc_q.size() != n) $display("FAIL scroll_count: got %0d expected %0d (period %0d)", pulse_cyc_q.size(), n, per);
    else n_pass++;
    for (int i = 0; i < n && i < pulse_cyc_q.size(); i++) begin
      n_checks++;
      if (pulse_dat_q[i] !== exp_q[i]) $display("FAIL scroll_data[%0d]: got %h expected %h", i, pulse_dat_q[i], exp_q[i]);
      else n_pass++;
      n_checks++;
      if (pulse_cyc_q[i] != e + per + 2 + i * (per + 2))
        $display("FAIL scroll_time[%0d]: got cycle %0d expected %0d", i, pulse_cyc_q[i], e + per + 2 + i * (per + 2));
      else n_pass++;
    end
    n_checks++; if (status !== 8'h30) $display("FAIL scroll_status: got %h expected 30", status); else n_pass++;
  endtask

  task automatic test_overflow();
    int e;
    logic [15:0] w;
    logic [3:0] nib;
    do_reset();
    w = '0;
    for (int i = 0; i < 17; i++) begin
      nib = 4'($urandom_range(0, 15));
      bus_write(BASE, {28'h0, nib}, 1'b1);
      if (i < 16) begin
        w = shift_in(w, nib);
        exp_q.push_back(w);
      end
    end
    n_checks++; if (status !== 8'hCF) $display("FAIL overflow_status: got %h expected cf", status); else n_pass++;
    bus_write(BASE + 32'd1, 32'h0000_0001, 1'b1);
    e = last_wr_cyc;
    repeat (16 * 2 + 10) @(negedge clk);
    n_checks++; if (pulse_cyc_q.size() != 16) $display("FAIL overflow_count: got %0d expected 16", pulse_cyc_q.size()); else n_pass++;
    for (int i = 0; i < 16 && i < pulse_cyc_q.size(); i++) begin
      n_checks++;
      if (pulse_dat_q[i] !== exp_q[i]) $display("FAIL overflow_data[%0d]: got %h expected %h", i, pulse_dat_q[i], exp_q[i]);
      else n_pass++;
      n_checks++;
      if (pulse_cyc_q[i] != e + 2 + 2 * i) $display("FAIL overflow_time[%0d]: got cycle %0d expected %0d", i, pulse_cyc_q[i], e + 2 + 2 * i);
      else n_pass++;
    end
    n_checks++; if (status !== 8'hB0) $display("FAIL overflow_drained_status: got %h expected b0", status); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e, per, target;
    logic [15:0] w;
    logic [3:0] nib;
    do_reset();
    w = '0;
    for (int i = 0; i < 16; i++) begin
      nib = 4'($urandom_range(0, 15));
      bus_write(BASE, {28'h0, nib}, 1'b1);
      w = shift_in(w, nib);
    end
    per = $urandom_range(1, 4);
    bus_write(BASE + 32'd1, {per[23:0], 8'h01}, 1'b1);
    e = last_wr_cyc;
    target = e + per + 1;
    while (cyc < target) @(negedge clk);
    nib = 4'($urandom_range(0, 15));
    bus_write(BASE, {28'h0, nib}, 1'b1);
    w = shift_in(w, nib);
    n_checks++; if (status !== 8'h5F) $display("FAIL full_push_pop_status: got %h expected 5f", status); else n_pass++;
    n_checks++; if (out_enable !== 1'b1) $display("FAIL full_push_pop_emit: got %b expected 1", out_enable); else n_pass++;
    repeat (17 * (per + 2) + 10) @(negedge clk);
    n_checks++; if (pulse_cyc_q.size() != 17) $display("FAIL full_push_pop_count: got %0d expected 17", pulse_cyc_q.size()); else n_pass++;
    if (pulse_dat_q.size() > 0) begin
      n_checks++;
      if (pulse_dat_q[pulse_dat_q.size() - 1] !== w)
        $display("FAIL full_push_pop_last: got %h expected %h", pulse_dat_q[pulse_dat_q.size() - 1], w);
      else n_pass++;
    end
    n_checks++; if (status !== 8'h30) $display("FAIL full_push_pop_final_status: got %h expected 30", status); else n_pass++;
  endtask

  task automatic test_clear();
    int e, budget, after;
    logic [3:0] a, b;
    logic [15:0] got [$];
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(BASE, 32'($urandom_range(0, 15)), 1'b1);
    bus_write(BASE + 32'd1, {24'd1, 8'h01}, 1'b1);
    budget = 100;
    while (pulse_cyc_q.size() < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++; if (budget == 0) $display("FAIL clear_wait: got no pulses expected 2 within 100 cycles"); else n_pass++;
    bus_write(BASE + 32'd1, 32'h0000_0003, 1'b1);
    e = last_wr_cyc;
    n_checks++; if (out_enable !== 1'b1) $display("FAIL clear_emit: got %b expected 1", out_enable); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL clear_data: got %h expected 0", out_data); else n_pass++;
    n_checks++; if (status !== 8'h30) $display("FAIL clear_status: got %h expected 30", status); else n_pass++;
    repeat (10) @(negedge clk);
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    bus_write(BASE, {28'h0, a}, 1'b1);
    bus_write(BASE, {28'h0, b}, 1'b1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < pulse_cyc_q.size(); i++)
      if (pulse_cyc_q[i] >= e) got.push_back(pulse_dat_q[i]);
    after = got.size();
    n_checks++; if (after != 3) $display("FAIL clear_pulse_count: got %0d expected 3", after); else n_pass++;
    if (after == 3) begin
      n_checks++; if (got[0] !== 16'h0) $display("FAIL clear_pulse0: got %h expected 0", got[0]); else n_pass++;
      n_checks++; if (got[1] !== {12'h0, a}) $display("FAIL clear_pulse1: got %h expected %h", got[1], {12'h0, a}); else n_pass++;
      n_checks++; if (got[2] !== {8'h0, a, b}) $display("FAIL clear_pulse2: got %h expected %h", got[2], {8'h0, a, b}); else n_pass++;
    end
  endtask

  task automatic test_stop_in_emit();
    int budget;
    do_reset();
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'($urandom_range(0, 15)), 1'b1);
    bus_write(BASE + 32'd1, {24'd2, 8'h01}, 1'b1);
    budget = 30;
    while (out_enable !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++; if (budget == 0) $display("FAIL stop_wait: got no pulse expected one within 30 cycles"); else n_pass++;
    bus_write(BASE + 32'd1, {24'd2, 8'h00}, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++; if (pulse_cyc_q.size() != 1) $display("FAIL stop_pulses: got %0d expected 1", pulse_cyc_q.size()); else n_pass++;
    n_checks++; if (status !== 8'h02) $display("FAIL stop_status: got %h expected 02", status); else n_pass++;
  endtask

  task automatic test_reset_in_emit();
    int budget;
    logic [3:0] nib;
    do_reset();
    nib = 4'($urandom_range(1, 15));
    bus_write(BASE, {28'h0, nib}, 1'b1);
    bus_write(BASE + 32'd1, 32'h0000_0001, 1'b1);
    budget = 20;
    while (out_enable !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++; if (out_data !== {28'h0, nib}) $display("FAIL rst_emit_data: got %h expected %h", out_data, {28'h0, nib}); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_enable !== 1'b0) $display("FAIL rst_emit_out_enable: got %b expected 0", out_enable); else n_pass++;
    n_checks++; if (out_rw !== 1'b0) $display("FAIL rst_emit_out_rw: got %b expected 0", out_rw); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL rst_emit_out_data: got %h expected 0", out_data); else n_pass++;
    n_checks++; if (status !== 8'h20) $display("FAIL rst_emit_status: got %h expected 20", status); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_no_push();
    test_scroll(1'b1);
    for (int k = 0; k < 3; k++) test_scroll(1'b0);
    test_overflow();
    test_back_to_back();
    test_clear();
    test_stop_in_emit();
    test_reset_in_emit();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
